// File: rtl/l1ca_code_ctrl_pkg.sv
// Shared types for the C/A code sequencer: command opcodes, sequencer
// states, slew word type and chip index type, plus the slew clamp helper.
package l1ca_code_ctrl_pkg;

  localparam int CA_CODE_LEN = 1023;

  typedef logic signed [10:0] slew_t;
  typedef logic [9:0]         chip_t;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    SET_SV  = 2'd1,
    SLEW    = 2'd2,
    RESTART = 2'd3
  } code_cmd_op_t;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    ADV = 2'd1,
    RET = 2'd2,
    CLR = 2'd3
  } ctrl_state_t;

  // Magnitude of a signed slew, clamped to one code period so that -1024
  // (the only value whose magnitude does not fit) behaves as -1023.
  function automatic logic [9:0] slew_mag(input slew_t s);
    logic [10:0] mag;
    mag = s[10] ? 11'(-s) : 11'(s);
    if (mag > 11'(CA_CODE_LEN)) begin
      return 10'(CA_CODE_LEN);
    end
    return mag[9:0];
  endfunction

endpackage

// File: rtl/l1ca_code_ctrl_if.sv
// Command handshake between channel software and the code sequencer.
// The master presents an opcode with its arguments and holds it until
// cmd_ready is seen high on the same cycle as cmd_valid.
interface l1ca_code_ctrl_if;
  import l1ca_code_ctrl_pkg::*;

  logic         cmd_valid;
  logic         cmd_ready;
  code_cmd_op_t cmd_op;
  logic [4:0]   cmd_sv;
  slew_t        cmd_slew;

  modport master (output cmd_valid, output cmd_op, output cmd_sv,
                  output cmd_slew, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_sv,
                  input cmd_slew, output cmd_ready);
endinterface

// File: rtl/l1ca_code_ctrl_nco.sv
// Phase accumulator NCO. The tick is the carry-out of this cycle's add and
// is only produced while run is high; a synchronous clear zeroes the phase.
// Kept generic so the carrier NCO can reuse it.
module code_nco #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         run,
  input  logic         clear,
  input  logic [W-1:0] fcw,
  output logic [W-1:0] acc,
  output logic         tick
);

  logic [W:0] sum;

  assign sum  = {1'b0, acc} + {1'b0, fcw};
  assign tick = run & sum[W];

  // Phase update: clear wins, otherwise advance only while running.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (run) begin
      acc <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/l1ca_code_ctrl.sv
// Code sequencer for one C/A generator in a tracking channel: owns the
// code NCO, executes SET_SV / RESTART / SLEW commands and counts epochs.
// Optional feature macro: L1CA_CODE_CTRL_PHASE_OUT_EN adds the registered
// code_phase output (integer chip plus fractional NCO phase).
module l1ca_code_ctrl
  import l1ca_code_ctrl_pkg::*;
#(
  parameter int NCO_W   = 32,
  parameter int FRAC_W  = 8,
  parameter int EPOCH_W = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                run,
  input  logic [NCO_W-1:0]    cfg_fcw,
  l1ca_code_ctrl_if.slave     cmd,
  output logic                gen_en,
  output logic                gen_clear,
  output logic [4:0]          gen_sv,
  input  logic                gen_epoch,
  input  chip_t               gen_chip,
  output logic                busy,
  output logic [EPOCH_W-1:0]  epoch_cnt
`ifdef L1CA_CODE_CTRL_PHASE_OUT_EN
  ,
  output logic [10+FRAC_W-1:0] code_phase
`endif
);

  ctrl_state_t      state;
  logic [9:0]       remaining;
  logic             epoch_q;
  logic [NCO_W-1:0] acc;
  logic             tick;
  logic             accept;
  logic             do_clear;

  assign cmd.cmd_ready = (state == RUN);
  assign accept        = cmd.cmd_valid & (state == RUN);
  assign do_clear      = accept & ((cmd.cmd_op == SET_SV) | (cmd.cmd_op == RESTART));

  code_nco #(.W(NCO_W)) u_nco (
    .clk   (clk),
    .nrst  (nrst),
    .run   (run),
    .clear (do_clear),
    .fcw   (cfg_fcw),
    .acc   (acc),
    .tick  (tick)
  );

  // Sequencer: normal chipping, advance bursts, retard suppression, clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= RUN;
      gen_en    <= 1'b0;
      gen_clear <= 1'b0;
      gen_sv    <= 5'd0;
      busy      <= 1'b0;
      remaining <= 10'd0;
    end else begin
      case (state)
        RUN: begin
          gen_en    <= tick;
          gen_clear <= 1'b0;
          busy      <= 1'b0;
          if (accept) begin
            case (cmd.cmd_op)
              SLEW: begin
                if (cmd.cmd_slew != '0) begin
                  remaining <= slew_mag(cmd.cmd_slew);
                  state     <= cmd.cmd_slew[10] ? RET : ADV;
                  busy      <= 1'b1;
                end
              end
              SET_SV: begin
                gen_sv    <= cmd.cmd_sv;
                gen_clear <= 1'b1;
                gen_en    <= 1'b0;
                state     <= CLR;
                busy      <= 1'b1;
              end
              RESTART: begin
                gen_clear <= 1'b1;
                gen_en    <= 1'b0;
                state     <= CLR;
                busy      <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        ADV: begin
          gen_en <= 1'b1;
          if ((remaining == 10'd1) && !tick) begin
            remaining <= 10'd0;
            state     <= RUN;
            busy      <= 1'b0;
          end else begin
            remaining <= remaining - 10'd1 + {9'd0, tick};
          end
        end
        RET: begin
          gen_en <= 1'b0;
          if (tick) begin
            remaining <= remaining - 10'd1;
            if (remaining == 10'd1) begin
              state <= RUN;
              busy  <= 1'b0;
            end
          end
        end
        CLR: begin
          gen_clear <= 1'b0;
          gen_en    <= 1'b0;
          state     <= RUN;
          busy      <= 1'b0;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Epoch counter: counts rising edges of the generator epoch flag, cleared
  // by SET_SV/RESTART with priority over a coincident edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      epoch_q   <= 1'b0;
      epoch_cnt <= '0;
    end else begin
      epoch_q <= gen_epoch;
      if (do_clear) begin
        epoch_cnt <= '0;
      end else if (gen_epoch && !epoch_q) begin
        epoch_cnt <= epoch_cnt + 1'b1;
      end
    end
  end

`ifdef L1CA_CODE_CTRL_PHASE_OUT_EN
  // Code phase snapshot: chip index with the top fractional NCO bits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      code_phase <= '0;
    end else begin
      code_phase <= {gen_chip, acc[NCO_W-1 -: FRAC_W]};
    end
  end

  logic unused_bits;
  assign unused_bits = ^acc;
`else
  logic unused_bits;
  assign unused_bits = ^{gen_chip, acc[NCO_W-1 -: FRAC_W], acc};
`endif

endmodule

// File: tb/tb_l1ca_code_ctrl.sv
// Directed/randomized bench for the C/A code sequencer. A small generator
// stand-in turns gen_en/gen_clear into chip and epoch; expected chips come
// from closed-form NCO arithmetic: ticks(n) = floor(n*fcw / 2^32).
module tb_l1ca_code_ctrl;
  import l1ca_code_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] cfg_fcw = '0;
  logic        gen_en, gen_clear, busy, gen_epoch;
  logic [4:0]  gen_sv;
  logic [15:0] epoch_cnt;
  chip_t       gen_chip;
`ifdef L1CA_CODE_CTRL_PHASE_OUT_EN
  logic [17:0] code_phase;
`endif

  l1ca_code_ctrl_if cmd_if();

  l1ca_code_ctrl #(.NCO_W(32), .FRAC_W(8), .EPOCH_W(16)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .run       (run),
    .cfg_fcw   (cfg_fcw),
    .cmd       (cmd_if),
    .gen_en    (gen_en),
    .gen_clear (gen_clear),
    .gen_sv    (gen_sv),
    .gen_epoch (gen_epoch),
    .gen_chip  (gen_chip),
    .busy      (busy),
    .epoch_cnt (epoch_cnt)
`ifdef L1CA_CODE_CTRL_PHASE_OUT_EN
    ,
    .code_phase(code_phase)
`endif
  );

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint clr_cyc = 0;
  longint fcw_m = 0;
  int     net = 0;

  always #5 clk = ~clk;

  // Edge counter used to index the closed-form NCO model.
  always @(posedge clk) cyc <= cyc + 1;

  // Generator stand-in: chip counter modulo 1023, epoch flag on wrap.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gen_chip  <= '0;
      gen_epoch <= 1'b0;
    end else begin
      gen_epoch <= 1'b0;
      if (gen_clear) begin
        gen_chip <= '0;
      end else if (gen_en) begin
        if (gen_chip == 10'd1022) begin
          gen_chip  <= '0;
          gen_epoch <= 1'b1;
        end else begin
          gen_chip <= gen_chip + 10'd1;
        end
      end
    end
  end

  function automatic longint ticks(input longint n);
    if (n <= 0) return 0;
    return (n * fcw_m) >>> 32;
  endfunction

  function automatic int predChip();
    longint c;
    c = ticks(cyc - clr_cyc - 1) + longint'(net);
    return int'(((c % 1023) + 1023) % 1023);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic setFcw(input longint f);
    fcw_m   = f;
    cfg_fcw = 32'(f);
  endtask

  // Present a command at the current falling edge and hold it until taken.
  task automatic applyStimulus(input code_cmd_op_t op, input logic [4:0] sv,
                               input int slew);
    int guard;
    guard = 0;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_sv    = sv;
    cmd_if.cmd_slew  = slew_t'(slew);
    cmd_if.cmd_valid = 1'b1;
    while (!cmd_if.cmd_ready && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = NOP;
    if (op == SET_SV || op == RESTART) begin
      clr_cyc = cyc;
      net     = 0;
    end
  endtask

  task automatic waitChip(input int target, input int limit);
    int guard;
    guard = 0;
    while (gen_chip != 10'(target) && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("chip_reached", gen_chip, target);
  endtask

  task automatic runSlew(input int n, input string tag);
    int     pulses;
    int     guard;
    int     mag;
    longint e_a;
    longint e_x;
    pulses = 0;
    guard  = 0;
    applyStimulus(SLEW, 5'd0, n);
    checkOutput({tag, "_busy_rise"}, busy, 1);
    e_a = cyc - clr_cyc;
    do begin
      @(negedge clk);
      pulses += int'(gen_en);
      guard++;
    end while (busy && guard < 8000);
    checkOutput({tag, "_busy_fall"}, busy, 0);
    e_x = cyc - clr_cyc;
    mag = (n > 0) ? n : ((-n > 1023) ? 1023 : -n);
    if (n > 0) begin
      checkOutput({tag, "_burst_pulses"}, pulses, mag + ticks(e_x) - ticks(e_a));
      net += mag;
    end else begin
      checkOutput({tag, "_ret_pulses"}, pulses, 0);
      checkOutput({tag, "_ret_ticks"}, ticks(e_x) - ticks(e_a), mag);
      net -= mag;
    end
    repeat (2) @(negedge clk);
    checkOutput({tag, "_chip"}, gen_chip, predChip());
  endtask

  initial begin
    longint     c0;
    int         guard;
    int         pulses;
    int         n_r;
    logic [4:0] sv_r;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = NOP;
    cmd_if.cmd_sv    = '0;
    cmd_if.cmd_slew  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_gen_en", gen_en, 0);
    checkOutput("rst_gen_clear", gen_clear, 0);
    checkOutput("rst_gen_sv", gen_sv, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_epoch_cnt", epoch_cnt, 0);
    checkOutput("rst_cmd_ready", cmd_if.cmd_ready, 1);

    // Quarter-rate chipping straight out of reset.
    nrst = 1'b1;
    setFcw(64'h4000_0000);
    run = 1'b1;
    c0 = cyc;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checkOutput("nco_gen_en", gen_en, ticks(cyc - c0) - ticks(cyc - c0 - 1));
      pulses += int'(gen_en);
    end
    checkOutput("nco_pulse_count", pulses, 10);
    checkOutput("nco_busy", busy, 0);

    // SET_SV 7.
    applyStimulus(SET_SV, 5'd7, 0);
    checkOutput("setsv_gen_sv", gen_sv, 7);
    checkOutput("setsv_gen_clear", gen_clear, 1);
    checkOutput("setsv_epoch_cnt", epoch_cnt, 0);
    checkOutput("setsv_cmd_ready", cmd_if.cmd_ready, 0);
    checkOutput("setsv_busy", busy, 1);
    @(negedge clk);
    checkOutput("setsv_clear_fall", gen_clear, 0);
    checkOutput("setsv_ready_back", cmd_if.cmd_ready, 1);
    checkOutput("setsv_clr_gen_en", gen_en, 0);

    // Advance and retard slews, including the -1024 clamp.
    waitChip(100, 2000);
    checkOutput("chip_at_100_model", gen_chip, predChip());
    runSlew(50, "adv50");
    waitChip(300, 2000);
    runSlew(-20, "ret20");
    runSlew(-1024, "ret1024");

    // Randomized rate after RESTART; sv must survive.
    setFcw(longint'($urandom_range(32'h1000_0000, 32'h8000_0000)));
    applyStimulus(RESTART, 5'd0, 0);
    checkOutput("restart_gen_sv", gen_sv, 7);
    checkOutput("restart_clear", gen_clear, 1);
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checkOutput("rand_gen_en", gen_en,
                  ticks(cyc - clr_cyc) - ticks(cyc - clr_cyc - 1));
    end
    n_r = int'($urandom_range(1, 200));
    runSlew(n_r, "rand_adv");
    n_r = int'($urandom_range(1, 200));
    runSlew(-n_r, "rand_ret");

    // Epoch counting over three code periods at half rate.
    setFcw(64'h8000_0000);
    guard = 0;
    while ((gen_chip < 10'd5 || gen_chip > 10'd1000) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    sv_r = 5'($urandom_range(0, 31));
    applyStimulus(SET_SV, sv_r, 0);
    checkOutput("epoch_setsv_sv", gen_sv, sv_r);
    guard = 0;
    while (ticks(cyc - clr_cyc - 1) < 64'd3119 && guard < 9000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("epoch_cnt_3", epoch_cnt, 3);
    checkOutput("epoch_chip", gen_chip, predChip());
    guard = 0;
    while (!gen_epoch && guard < 2500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("epoch_edge_seen", gen_epoch, 1);
    checkOutput("epoch_cnt_pre_clear", epoch_cnt, 3);
    applyStimulus(SET_SV, sv_r, 0);
    checkOutput("epoch_clear_priority", epoch_cnt, 0);
    repeat (4) @(negedge clk);
    checkOutput("epoch_stays_clear", epoch_cnt, 0);

    // Reset in the middle of a long advance burst.
    setFcw(64'h4000_0000);
    applyStimulus(SLEW, 5'd0, 500);
    repeat (10) @(negedge clk);
    checkOutput("midadv_busy", busy, 1);
    nrst = 1'b0;
    run  = 1'b0;
    #1;
    checkOutput("midrst_gen_en", gen_en, 0);
    checkOutput("midrst_gen_clear", gen_clear, 0);
    checkOutput("midrst_gen_sv", gen_sv, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_epoch_cnt", epoch_cnt, 0);
    checkOutput("midrst_cmd_ready", cmd_if.cmd_ready, 1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("postrst_no_en", gen_en, 0);
    end
    checkOutput("postrst_busy", busy, 0);
    checkOutput("postrst_ready", cmd_if.cmd_ready, 1);
    run = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput("postrst_gen_en", gen_en, ticks(cyc - c0) - ticks(cyc - c0 - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1ca_code_ctrl.md
Name: l1ca_code_ctrl

Overview:
Sequencer for one l1ca_code generator instance inside a tracking channel.
- Owns the code NCO that turns the chipping-rate frequency word into per-chip gen_en pulses.
- Executes software commands: select SV (with generator clear), and slew code phase by a signed chip count (advance via burst enables, retard via suppressed enables).
- Counts code epochs for the channel's ms timebase.

Parameters:
- NCO_W, 32, code NCO accumulator width; chip tick = accumulator carry-out.
- FRAC_W, 8, fractional code-phase bits exported under the optional feature; FRAC_W <= NCO_W.
- EPOCH_W, 16, width of the epoch counter.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- run  in  1  1 = NCO advances and chips are issued; 0 = NCO frozen, gen_en held 0
- cfg_fcw  in  NCO_W  code frequency word; chip rate = fclk*cfg_fcw/2^NCO_W; must be <= 2^(NCO_W-1)
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  code_cmd_op_t: NOP=0, SET_SV=1, SLEW=2, RESTART=3
- cmd_sv  in  5  SV index for SET_SV
- cmd_slew  in  11  signed chips for SLEW; +advance, -retard
- gen_en  out  1  to l1ca_code en
- gen_clear  out  1  to l1ca_code clear
- gen_sv  out  5  to l1ca_code sv
- gen_epoch  in  1  from l1ca_code epoch
- gen_chip  in  chip_t  from l1ca_code chip
- busy  out  1  slew or clear in progress
- epoch_cnt  out  EPOCH_W  epochs seen since last SET_SV/RESTART, wraps

Behaviour:
- Reset: acc=0, state=RUN, gen_en=0, gen_clear=0, gen_sv=0, busy=0, epoch_cnt=0, remaining=0, epoch_q=0.
- All outputs are registered except cmd_ready = (state==RUN).
- NCO: while run=1, {tick, acc} <= acc + cfg_fcw each cycle. While run=0, acc holds and tick=0. gen_en is asserted one cycle after the tick cycle.
- States:
  - RUN: gen_en <= tick.
    - Accepted NOP: no effect.
    - SLEW with 0: no effect, stay RUN.
    - SLEW with n>0: remaining <= min(n,1023), go to ADV.
    - SLEW with n<0: remaining <= min(|n|,1023), go to RET.
    - SET_SV: gen_sv <= cmd_sv, gen_clear <= 1, acc <= 0, epoch_cnt <= 0, go to CLR.
    - RESTART: same as SET_SV but gen_sv is unchanged.
  - ADV: gen_en <= 1 every cycle. remaining <= remaining - 1 + tick, so NCO ticks owed during the burst are still issued. Go to RUN when remaining==1 and tick==0.
  - RET: gen_en <= 0. remaining <= remaining - tick. Go to RUN on the cycle remaining==1 and tick==1; that tick is consumed.
  - CLR: lasts exactly one cycle. gen_clear <= 0, gen_en <= 0, and any tick in this cycle is dropped. Then go to RUN.
  - busy <= (next state != RUN).
- run=0 during ADV: the burst still completes. run=0 during RET: the state holds because no ticks occur.
- A tick in the same cycle as command acceptance: in RUN, gen_en <= tick still applies for SLEW/NOP. For SET_SV/RESTART the tick is dropped.
- Epochs: epoch_q <= gen_epoch. epoch_cnt increments when gen_epoch & ~epoch_q, wrapping at 2^EPOCH_W. SET_SV/RESTART clearing takes priority over an increment in the same cycle.
- cmd_slew = -1024 is clamped to magnitude 1023.
- Reset asserted mid-slew or mid-clear immediately returns all state to its reset values. Commands presented while cmd_ready=0 are held by the master, not dropped.

Optional Feature:
- Macro: L1CA_CODE_CTRL_PHASE_OUT_EN.
- Defined: adds output port code_phase [10+FRAC_W-1:0] = {gen_chip, acc[NCO_W-1 -: FRAC_W]}, registered, reset value 0, for the discriminator/loop.
- Undefined: the port and its register do not exist.

Decomposition:
- Add to common_gnss_types_pkg:
  - code_cmd_op_t enum
  - ctrl_state_t enum (RUN, ADV, RET, CLR)
  - localparam CA_CODE_LEN = 1023
  - slew_t = logic signed [10:0]
- One sub-module: code_nco (accumulator, run gate, synchronous zero, carry-out tick). Instantiated once; reused by the carrier NCO later.

Test Plan:
- cfg_fcw = 2^(NCO_W-2), run=1 for 40 cycles -> gen_en high on exactly every 4th cycle (10 pulses), busy=0.
- SET_SV cmd_sv=7 -> next cycle gen_sv=7, gen_clear=1 for exactly 1 cycle, epoch_cnt=0, cmd_ready low for 1 cycle.
- fcw = 2^(NCO_W-2), at gen_chip=100, SLEW +50 -> gen_chip advances by 50 beyond the NCO-predicted chip when busy falls; count of gen_en pulses during ADV = 50 + ticks in window.
- SLEW -20 at gen_chip=300 -> exactly 20 NCO ticks produce no gen_en; gen_chip lags the NCO-predicted chip by 20 at end; SLEW -1024 behaves as -1023.
- Run 3 full code periods after SET_SV -> epoch_cnt=3; SET_SV in the same cycle as an epoch edge -> epoch_cnt=0.
- Assert nrst low during ADV with remaining=500 -> all outputs at reset values, cmd_ready=1 after release, no residual enables.
